// File: rtl/b2a_serial_conv_if.sv
// Handshake and data bundle for the bit-serial Boolean-to-arithmetic converter.
// Signal names are taken from the converter's point of view.
interface b2a_serial_conv_if #(
    parameter int K = 16
);
    logic         valid_i;
    logic         ready_o;
    logic [K-1:0] x0_i;
    logic [K-1:0] x1_i;
    logic [K-1:0] a_i;
    logic [K-1:0] m_i;
    logic [2:0]   rnd_i;
    logic         valid_o;
    logic         ready_i;
    logic [K-1:0] a0_o;
    logic [K-1:0] a1_o;

    modport master (
        output valid_i, x0_i, x1_i, a_i, m_i, rnd_i, ready_i,
        input  ready_o, valid_o, a0_o, a1_o
    );

    modport slave (
        input  valid_i, x0_i, x1_i, a_i, m_i, rnd_i, ready_i,
        output ready_o, valid_o, a0_o, a1_o
    );
endinterface

// File: rtl/b2a_serial_conv.sv
// First-order bit-serial Boolean-to-arithmetic mask converter (x0^x1 -> A0+A1).
// Optional B2A_SHARE_CLEAR_EN wipes share registers and outputs on handshake.
module b2a_serial_conv #(
    parameter int K = 16
) (
    input logic              clk_i,
    input logic              rst_ni,
    b2a_serial_conv_if.slave bus
);
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    typedef enum logic [1:0] {IDLE, ADD, RECOMB, OUT} st_e;

    st_e          state_q, state_d;
    logic         ready_q, ready_d;
    logic         valid_q, valid_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [K-1:0] x0_q, x0_d, x1_q, x1_d;
    logic [K-1:0] y0_q, y0_d, y1_q, y1_d;
    logic [K-1:0] z0_q, z0_d, z1_q, z1_d;
    logic [K-1:0] a_q, a_d;
    logic [K-1:0] a0_q, a0_d, a1_q, a1_d;
    logic         c0_q, c0_d, c1_q, c1_d;

    // ISW AND on two shares; r refreshes the cross terms
    function automatic logic [1:0] sec_and(
        input logic p0, input logic p1,
        input logic q0, input logic q1,
        input logic r
    );
        logic t;
        t = (p0 & q1) ^ r;
        t = t ^ (p1 & q0);
        return {(p1 & q1) ^ t, (p0 & q0) ^ r};
    endfunction

    logic       xb0, xb1, yb0, yb1;
    logic [1:0] g_xy, g_xc, g_yc;

    always_comb begin
        xb0  = x0_q[cnt_q];
        xb1  = x1_q[cnt_q];
        yb0  = y0_q[cnt_q];
        yb1  = y1_q[cnt_q];
        g_xy = sec_and(xb0, xb1, yb0, yb1, bus.rnd_i[0]);
        g_xc = sec_and(xb0, xb1, c0_q, c1_q, bus.rnd_i[1]);
        g_yc = sec_and(yb0, yb1, c0_q, c1_q, bus.rnd_i[2]);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
        y0_d    = y0_q;
        y1_d    = y1_q;
        z0_d    = z0_q;
        z1_d    = z1_q;
        a_d     = a_q;
        a0_d    = a0_q;
        a1_d    = a1_q;
        c0_d    = c0_q;
        c1_d    = c1_q;
        unique case (state_q)
            IDLE: begin
                if (bus.valid_i && ready_q) begin
                    x0_d    = bus.x0_i;
                    x1_d    = bus.x1_i;
                    a_d     = bus.a_i;
                    y0_d    = bus.m_i;
                    y1_d    = ({K{1'b0}} - bus.a_i) ^ bus.m_i;
                    c0_d    = 1'b0;
                    c1_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                // each share path stays separate; only SecAnd mixes them
                z0_d[cnt_q] = xb0 ^ yb0 ^ c0_q;
                z1_d[cnt_q] = xb1 ^ yb1 ^ c1_q;
                c0_d  = g_xy[0] ^ g_xc[0] ^ g_yc[0];
                c1_d  = g_xy[1] ^ g_xc[1] ^ g_yc[1];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = RECOMB;
            end
            RECOMB: begin
                a0_d    = z0_q ^ z1_q;
                a1_d    = a_q;
                state_d = OUT;
            end
            OUT: begin
                if (valid_q && bus.ready_i) begin
                    state_d = IDLE;
`ifdef B2A_SHARE_CLEAR_EN
                    x0_d = '0;
                    x1_d = '0;
                    y0_d = '0;
                    y1_d = '0;
                    z0_d = '0;
                    z1_d = '0;
                    c0_d = 1'b0;
                    c1_d = 1'b0;
                    a0_d = '0;
                    a1_d = '0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        valid_d = (state_q == OUT) && (state_d == OUT);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            x0_q    <= '0;
            x1_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            z0_q    <= '0;
            z1_q    <= '0;
            a_q     <= '0;
            a0_q    <= '0;
            a1_q    <= '0;
            c0_q    <= 1'b0;
            c1_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            z0_q    <= z0_d;
            z1_q    <= z1_d;
            a_q     <= a_d;
            a0_q    <= a0_d;
            a1_q    <= a1_d;
            c0_q    <= c0_d;
            c1_q    <= c1_d;
        end
    end

    assign bus.ready_o = ready_q;
    assign bus.valid_o = valid_q;
    assign bus.a0_o    = a0_q;
    assign bus.a1_o    = a1_q;
endmodule

// File: tb/tb_b2a_serial_conv.sv
// Self-checking bench for b2a_serial_conv: vector table, random stalls, reset abort.
// Build with +define+B2A_SHARE_CLEAR_EN to check the share-clearing variant.
module tb_b2a_serial_conv;
    localparam int K = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    b2a_serial_conv_if #(.K(K)) bus ();

    b2a_serial_conv #(.K(K)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [K-1:0] x0;
        logic [K-1:0] x1;
        logic [K-1:0] a;
        logic [K-1:0] m;
        logic [K-1:0] e0;
        logic [K-1:0] e1;
    } vec_t;

    typedef struct {
        logic [K-1:0] e0;
        logic [K-1:0] e1;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_junk(input bit busy_pulse);
        bus.valid_i = busy_pulse ? 1'($urandom % 2) : 1'b0;
        bus.x0_i    = K'($urandom);
        bus.x1_i    = K'($urandom);
        bus.a_i     = K'($urandom);
        bus.m_i     = K'($urandom);
        bus.rnd_i   = 3'($urandom);
    endtask

    task automatic start(input vec_t v);
        int n;
        exp_t e;
        n = 0;
        while (!bus.ready_o && n < 50) begin
            tick;
            n++;
        end
        chk("ready_wait", 32'(bus.ready_o), 32'd1);
        bus.x0_i    = v.x0;
        bus.x1_i    = v.x1;
        bus.a_i     = v.a;
        bus.m_i     = v.m;
        bus.rnd_i   = 3'($urandom);
        bus.valid_i = 1'b1;
        e.e0 = v.e0;
        e.e1 = v.e1;
        sb.push_back(e);
        tick;
        bus.valid_i = 1'b0;
    endtask

    task automatic convert(input vec_t v, input bit stall);
        int lat, n;
        bit done;
        exp_t e;
        logic [K-1:0] h0, h1;
        start(v);
        lat = 0;
        while (!bus.valid_o && lat < 100) begin
            chk("busy_ready", 32'(bus.ready_o), 32'd0);
            drive_junk(stall);
            bus.ready_i = stall ? 1'($urandom % 2) : 1'b1;
            tick;
            lat++;
        end
        chk("latency", 32'(lat), 32'(K + 2));
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: got empty expected entry");
            e.e0 = '0;
            e.e1 = '0;
        end else begin
            e = sb.pop_front();
        end
        chk("a0", 32'(bus.a0_o), 32'(e.e0));
        chk("a1", 32'(bus.a1_o), 32'(e.e1));
        h0 = bus.a0_o;
        h1 = bus.a1_o;
        done = 1'b0;
        n = 0;
        while (!done) begin
            bus.ready_i = (stall && n < 4) ? 1'($urandom % 2) : 1'b1;
            done = bus.ready_i;
            drive_junk(stall);
            tick;
            n++;
            if (!done) begin
                chk("stall_a0", 32'(bus.a0_o), 32'(h0));
                chk("stall_a1", 32'(bus.a1_o), 32'(h1));
                chk("stall_valid", 32'(bus.valid_o), 32'd1);
            end
        end
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        chk("post_valid", 32'(bus.valid_o), 32'd0);
        chk("post_ready", 32'(bus.ready_o), 32'd1);
`ifdef B2A_SHARE_CLEAR_EN
        chk("clr_a0", 32'(bus.a0_o), 32'd0);
        chk("clr_a1", 32'(bus.a1_o), 32'd0);
        chk("clr_x", 32'(dut.x0_q | dut.x1_q), 32'd0);
        chk("clr_y", 32'(dut.y0_q | dut.y1_q), 32'd0);
        chk("clr_z", 32'(dut.z0_q | dut.z1_q), 32'd0);
        chk("clr_c", 32'(dut.c0_q | dut.c1_q), 32'd0);
`else
        chk("hold_a0", 32'(bus.a0_o), 32'(h0));
        chk("hold_a1", 32'(bus.a1_o), 32'(h1));
`endif
    endtask

    initial begin
        vec_t tbl[6];
        vec_t v;
        logic [K-1:0] x;

        tbl[0] = '{16'hA5A5, 16'hB791, 16'h0001, 16'h3C3C, 16'h1233, 16'h0001};
        tbl[1] = '{16'h5A5A, 16'h5A5A, 16'h0001, 16'h0F0F, 16'hFFFF, 16'h0001};
        tbl[2] = '{16'h0F0F, 16'hF0F0, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000};
        tbl[3] = '{16'h8000, 16'h0000, 16'h8000, 16'h1234, 16'h0000, 16'h8000};
        tbl[4] = '{16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 16'h0000};
        tbl[5] = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'hAAAA, 16'hFFFF, 16'hFFFF};

        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        bus.x0_i    = '0;
        bus.x1_i    = '0;
        bus.a_i     = '0;
        bus.m_i     = '0;
        bus.rnd_i   = '0;

        #12;
        chk("rst_ready", 32'(bus.ready_o), 32'd1);
        chk("rst_valid", 32'(bus.valid_o), 32'd0);
        chk("rst_a0", 32'(bus.a0_o), 32'd0);
        chk("rst_a1", 32'(bus.a1_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;

        for (int i = 0; i < 6; i++) convert(tbl[i], 1'b0);

        // reset in the 8th ADD cycle must abort with no partial output
        start(tbl[0]);
        for (int i = 0; i < 7; i++) begin
            drive_junk(1'b1);
            tick;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_ready", 32'(bus.ready_o), 32'd1);
        chk("abort_valid", 32'(bus.valid_o), 32'd0);
        chk("abort_a0", 32'(bus.a0_o), 32'd0);
        chk("abort_a1", 32'(bus.a1_o), 32'd0);
        sb.delete();
        bus.valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        convert(tbl[0], 1'b0);

        for (int i = 0; i < 1000; i++) begin
            v.x0 = K'($urandom);
            v.x1 = K'($urandom);
            v.a  = K'($urandom);
            v.m  = K'($urandom);
            x    = v.x0 ^ v.x1;
            v.e0 = x - v.a;
            v.e1 = v.a;
            convert(v, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
